// File: rtl/ghost_cancel_ctrl.sv
// Run controller for the neighbour ghost-cancellation array: owns cancel enable and
// kill time, sequences trig_stop across run/stop/hold, and counts removed ghosts.
module ghost_cancel_ctrl #(
  parameter int NKEY  = 112,
  parameter int CNTW  = 16,
  parameter int KILLW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             trig,
  input  logic [NKEY-1:0]  vc_in,
  input  logic [NKEY-1:0]  vcr_in,
  input  logic [NKEY-1:0]  va_in,
  input  logic [NKEY-1:0]  varr_in,
  output logic             trig_stop,
  output logic             cancel_en,
  output logic [KILLW-1:0] kill_time,
  output logic             busy
);

  localparam int PW = $clog2(NKEY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t           r_state, w_next;
  logic             r_cancel_en;
  logic [KILLW-1:0] r_kill_time;
  logic [7:0]       r_hold;
  logic [7:0]       r_hold_cnt;
  logic [KILLW-1:0] r_drain_cnt;
  logic [CNTW-1:0]  r_ghost_c, r_ghost_a;
  logic [15:0]      r_cfg_rdata;
  logic [15:0]      w_rd_mux;
  logic [PW-1:0]    w_pop_c, w_pop_a;
  logic [CNTW:0]    w_sum_c, w_sum_a;
  logic             w_count_en, w_clr_c, w_clr_a;
  logic             w_unused_wdata;

  function automatic logic [PW-1:0] popcount(input logic [NKEY-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NKEY; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block's sensitivity to clk only.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run_req && !stop_req) w_next = S_ARM;
      S_ARM:   w_next = S_RUN;
      S_RUN:   if (stop_req) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    trig_stop = 1'b1;
    busy      = 1'b0;
    case (r_state)
      S_ARM:   busy = 1'b1;
      S_RUN:   begin busy = 1'b1; trig_stop = (r_hold_cnt != 8'd0); end
      S_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // Drain length is loaded on the stop edge; kill_time is frozen outside IDLE so it is stable here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
      r_hold_cnt  <= 8'd0;
    end else begin
      if (r_state == S_RUN && stop_req)             r_drain_cnt <= r_kill_time;
      else if (r_state == S_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;

      if (r_state != S_RUN || stop_req)         r_hold_cnt <= 8'd0;
      else if (trig && r_hold != 8'd0)          r_hold_cnt <= r_hold;
      else if (r_hold_cnt != 8'd0)              r_hold_cnt <= r_hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cancel_en <= 1'b1;
      r_kill_time <= KILLW'(4);
      r_hold      <= 8'd0;
    end else if (cfg_we) begin
      if (cfg_addr == 2'd0) begin
        r_cancel_en <= cfg_wdata[0];
        if (r_state == S_IDLE) r_kill_time <= cfg_wdata[KILLW:1];
      end
      if (cfg_addr == 2'd1) r_hold <= cfg_wdata[7:0];
    end
  end

  assign w_unused_wdata = ^cfg_wdata[15:8];

  assign w_pop_c    = popcount(vc_in & ~vcr_in);
  assign w_pop_a    = popcount(va_in & ~varr_in);
  assign w_sum_c    = {1'b0, r_ghost_c} + {{(CNTW + 1 - PW){1'b0}}, w_pop_c};
  assign w_sum_a    = {1'b0, r_ghost_a} + {{(CNTW + 1 - PW){1'b0}}, w_pop_a};
  assign w_count_en = (r_state == S_RUN) && !trig_stop;
  assign w_clr_c    = (r_state == S_ARM) || (cfg_we && cfg_addr == 2'd2);
  assign w_clr_a    = (r_state == S_ARM) || (cfg_we && cfg_addr == 2'd3);

  // Clear takes priority over a same-cycle increment; a carry out pins the count at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ghost_c <= '0;
      r_ghost_a <= '0;
    end else begin
      if (w_clr_c)         r_ghost_c <= '0;
      else if (w_count_en) r_ghost_c <= w_sum_c[CNTW] ? '1 : w_sum_c[CNTW-1:0];
      if (w_clr_a)         r_ghost_a <= '0;
      else if (w_count_en) r_ghost_a <= w_sum_a[CNTW] ? '1 : w_sum_a[CNTW-1:0];
    end
  end

  always_comb begin
    w_rd_mux = 16'h0000;
    case (cfg_addr)
      2'd0: w_rd_mux[KILLW:0]  = {r_kill_time, r_cancel_en};
      2'd1: w_rd_mux[7:0]      = r_hold;
      2'd2: w_rd_mux[CNTW-1:0] = r_ghost_c;
      2'd3: w_rd_mux[CNTW-1:0] = r_ghost_a;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_cfg_rdata <= 16'h0000;
    else        r_cfg_rdata <= w_rd_mux;
  end

  assign cfg_rdata = r_cfg_rdata;
  assign cancel_en = r_cancel_en;
  assign kill_time = r_kill_time;

endmodule

// File: tb/tb_ghost_cancel_ctrl.sv
// Directed bench for ghost_cancel_ctrl: reset, run/drain sequencing, hold window,
// ghost counting, saturation/clear and request conflicts.
module tb_ghost_cancel_ctrl;

  localparam int NKEY = 112;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [15:0]     cfg_wdata;
  logic [15:0]     cfg_rdata;
  logic            run_req, stop_req, trig;
  logic [NKEY-1:0] vc_in, vcr_in, va_in, varr_in;
  logic            trig_stop, cancel_en, busy;
  logic [2:0]      kill_time;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ghost_cancel_ctrl #(.NKEY(NKEY), .CNTW(16), .KILLW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .run_req(run_req), .stop_req(stop_req), .trig(trig),
    .vc_in(vc_in), .vcr_in(vcr_in), .va_in(va_in), .varr_in(varr_in),
    .trig_stop(trig_stop), .cancel_en(cancel_en), .kill_time(kill_time), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    cfg_addr = a;
    @(negedge clk);
    check(tag, cfg_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
    run_req = 1'b0; stop_req = 1'b0; trig = 1'b0;
    vc_in = '0; vcr_in = '0; va_in = '0; varr_in = '0;

    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_trig_stop", 16'(trig_stop), 16'd1);
    check("rst_kill_time", 16'(kill_time), 16'd4);
    check("rst_cancel_en", 16'(cancel_en), 16'd1);
    check("rst_busy",      16'(busy),      16'd0);
    rd(2'd0, 16'h0009, "rst_rd_ctrl");
    rd(2'd1, 16'h0000, "rst_rd_hold");
    rd(2'd2, 16'h0000, "rst_rd_ghost_c");
    rd(2'd3, 16'h0000, "rst_rd_ghost_a");

    // run_req and stop_req together in IDLE: stop wins
    run_req = 1'b1; stop_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0; stop_req = 1'b0;
    check("conflict_busy0", 16'(busy), 16'd0);
    @(negedge clk);
    check("conflict_busy1", 16'(busy), 16'd0);

    wr(2'd1, 16'h0003);
    rd(2'd1, 16'h0003, "hold_readback");

    // Run start: one ARM cycle, then RUN
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    check("arm_busy",      16'(busy),      16'd1);
    check("arm_trig_stop", 16'(trig_stop), 16'd1);
    @(negedge clk);
    check("run_busy",      16'(busy),      16'd1);
    check("run_trig_stop", 16'(trig_stop), 16'd0);

    // Ghost count: 3 ghosts per cycle for 10 cycles
    vc_in = 112'h1F; vcr_in = 112'h05;
    repeat (10) @(negedge clk);
    vc_in = '0; vcr_in = '0;
    rd(2'd2, 16'd30, "ghost_c_30");

    // Hold window with retrigger at t+2
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check("hold_t1", 16'(trig_stop), 16'd1);
    @(negedge clk);
    trig = 1'b1;
    check("hold_t2", 16'(trig_stop), 16'd1);
    @(negedge clk);
    trig = 1'b0;
    check("hold_t3", 16'(trig_stop), 16'd1);
    @(negedge clk);
    check("hold_t4", 16'(trig_stop), 16'd1);
    @(negedge clk);
    check("hold_t5", 16'(trig_stop), 16'd1);
    @(negedge clk);
    check("hold_t6", 16'(trig_stop), 16'd0);

    // Ghost pattern inside a hold window adds nothing
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    vc_in = 112'h1F; vcr_in = 112'h05;
    repeat (3) @(negedge clk);
    vc_in = '0; vcr_in = '0;
    check("hold2_end", 16'(trig_stop), 16'd0);
    rd(2'd2, 16'd30, "ghost_c_hold");

    // kill_time write in RUN ignored, cancel_en still written
    wr(2'd0, 16'h0004);
    check("run_wr_cancel_en", 16'(cancel_en), 16'd0);
    check("run_wr_kill_time", 16'(kill_time), 16'd4);
    rd(2'd0, 16'h0008, "run_wr_rd_ctrl");

    // Stop: DRAIN for kill_time+1 = 5 cycles
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_busy_%0d", i), 16'(busy),      16'd1);
      check($sformatf("drain_ts_%0d", i),   16'(trig_stop), 16'd1);
      @(negedge clk);
    end
    check("drain_done_busy", 16'(busy),      16'd0);
    check("drain_done_ts",   16'(trig_stop), 16'd1);

    // Second run: ARM clears counters, then saturate GHOST_A
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    @(negedge clk);
    rd(2'd2, 16'h0000, "arm_clears_c");
    va_in = '1; varr_in = '0;
    repeat (585) @(negedge clk);
    va_in = 112'h7FF;
    @(negedge clk);
    va_in = '0;
    rd(2'd3, 16'hFFFB, "ghost_a_fffb");
    va_in = 112'h7F;
    @(negedge clk);
    va_in = '0;
    rd(2'd3, 16'hFFFF, "ghost_a_sat");

    // Clear-write concurrent with increment
    va_in = 112'h7F;
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 16'h0;
    @(negedge clk);
    cfg_we = 1'b0; va_in = '0;
    rd(2'd3, 16'h0000, "clear_wins");

    // Reset during DRAIN
    vc_in = 112'h1F; vcr_in = 112'h05; va_in = 112'h7F;
    repeat (2) @(negedge clk);
    vc_in = '0; vcr_in = '0; va_in = '0;
    rd(2'd2, 16'd6,  "pre_rst_c");
    rd(2'd3, 16'd14, "pre_rst_a");
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    check("drain2_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_drain_busy", 16'(busy),      16'd0);
    check("rst_drain_ts",   16'(trig_stop), 16'd1);
    rd(2'd2, 16'h0000, "rst_drain_c");
    rd(2'd3, 16'h0000, "rst_drain_a");
    rd(2'd0, 16'h0009, "rst_drain_ctrl");
    rd(2'd1, 16'h0000, "rst_drain_hold");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
